// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared state encoding and limits for the score tracker
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int          TICK_DIV_DEFAULT = 10000000;
    localparam logic [11:0] SCORE_MAX_BCD    = 12'h999;
    localparam logic [2:0]  LEVEL_MAX        = 3'd7;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one saturating BCD decade with ripple carry out
module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       sat,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (inc && !sat) begin
            digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Carry is combinational so the whole chain advances on the same edge.
    assign carry = inc && !sat && !clr && (digit_q == 4'd9);
    assign digit = digit_q;

endmodule

// File: rtl/score_tracker.sv
// rtl/score_tracker.sv - game FSM, point prescaler, BCD score, high score and speed level
module score_tracker
    import score_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int LEVEL_STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       collision,
    input  logic       pause,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] h1,
    output logic [3:0] h2,
    output logic [3:0] h3,
    output logic [1:0] state,
    output logic [2:0] speed_level,
    output logic       point_tick,
    output logic       new_high
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam int             SW         = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
    localparam logic [SW-1:0]  STEP_LAST  = SW'(LEVEL_STEP - 1);

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [2:0]    level_q;
    logic [SW-1:0] step_q;
    logic [11:0]   high_q;
    logic          point_tick_q;
    logic          new_high_q;

    logic [3:0]    d1_w, d2_w, d3_w;
    logic [11:0]   score;
    logic          enter_run;
    logic          wrap;
    logic          inc_ones;
    logic          sat;
    logic          carry1, carry2, carry_unused;

    assign score     = {d3_w, d2_w, d1_w};
    assign enter_run = start && (state_q != RUN);
    assign wrap      = (presc_q == PRESC_LAST);
    assign inc_ones  = (state_q == RUN) && !pause && !collision && wrap;
    assign sat       = (score == SCORE_MAX_BCD);

    bcd_digit u_ones (
        .clk(clk), .rst(rst), .clr(enter_run), .inc(inc_ones), .sat(sat),
        .digit(d1_w), .carry(carry1)
    );

    bcd_digit u_tens (
        .clk(clk), .rst(rst), .clr(enter_run), .inc(carry1), .sat(sat),
        .digit(d2_w), .carry(carry2)
    );

    bcd_digit u_hundreds (
        .clk(clk), .rst(rst), .clr(enter_run), .inc(carry2), .sat(sat),
        .digit(d3_w), .carry(carry_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            level_q      <= 3'd0;
            step_q       <= '0;
            high_q       <= 12'h000;
            point_tick_q <= 1'b0;
            new_high_q   <= 1'b0;
        end else begin
            point_tick_q <= 1'b0;
            new_high_q   <= 1'b0;
            case (state_q)
                IDLE, OVER: begin
                    if (start) begin
                        state_q <= RUN;
                        presc_q <= '0;
                        level_q <= 3'd0;
                        step_q  <= '0;
                    end
                end
                RUN: begin
                    if (collision) begin
                        state_q <= OVER;
                        // Valid BCD compares correctly as a plain binary number.
                        if (score > high_q) begin
                            high_q     <= score;
                            new_high_q <= 1'b1;
                        end
                    end else if (!pause) begin
                        presc_q      <= wrap ? '0 : presc_q + PW'(1);
                        point_tick_q <= wrap;
                        if (carry2) begin
                            if (step_q == STEP_LAST) begin
                                step_q <= '0;
                                if (level_q != LEVEL_MAX) begin
                                    level_q <= level_q + 3'd1;
                                end
                            end else begin
                                step_q <= step_q + SW'(1);
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign d1          = d1_w;
    assign d2          = d2_w;
    assign d3          = d3_w;
    assign h1          = high_q[3:0];
    assign h2          = high_q[7:4];
    assign h3          = high_q[11:8];
    assign state       = state_q;
    assign speed_level = level_q;
    assign point_tick  = point_tick_q;
    assign new_high    = new_high_q;

endmodule
